mem_access_unit: RTL

Memory-stage load/store unit sitting directly downstream of the execute stage, past the EX/MEM pipeline register. It consumes the ALU result as the address, the store data and the destination register. It drives a request/grant/response data-memory bus with byte enables and returns sign- or zero-extended load data to writeback. It stalls the pipeline while an access is outstanding.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/load_extend.sv | 41 ++++
 rtl/mem_access_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared funct3 encodings and FSM state type for the
//               memory-stage load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // RV32I load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32I store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Selects the addressed byte/half of a read word and sign- or
//               zero-extends it according to the load funct3.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection followed by extension; unknown funct3 passes the word through
  always_comb begin
    w_byte   = 8'h00;
    w_half   = offset[1] ? rdata[31:16] : rdata[15:0];
    data_ext = rdata;
    case (offset)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    case (funct3)
      F3_LB:   data_ext = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  data_ext = {24'h000000, w_byte};
      F3_LH:   data_ext = {{16{w_half[15]}}, w_half};
      F3_LHU:  data_ext = {16'h0000, w_half};
      default: data_ext = rdata;
    endcase
  end

endmodule : load_extend
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Memory-stage load/store unit. Issues one request/grant/
//               response bus access per load or store, stalls upstream while
//               busy and returns extended load data to writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] ALUResultM_i,
  input  logic [DATA_WIDTH-1:0] WriteDataM_i,
  input  logic                  MemReadM_i,
  input  logic                  MemWriteM_i,
  input  logic [2:0]            Funct3M_i,
  input  logic [4:0]            RdM_i,
  input  logic                  ValidM_i,
  output logic                  req_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [3:0]            be_o,
  input  logic                  gnt_i,
  input  logic                  rvalid_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] ReadDataM_o,
  output logic [4:0]            RdW_o,
  output logic                  DoneM_o,
  output logic                  StallM_o,
  output logic                  FaultM_o
);

  mem_state_t            r_state;
  logic [4:0]            r_rd;
  logic [2:0]            r_funct3;
  logic [1:0]            r_off;

  logic                  w_start;
  logic                  w_is_store;
  logic                  w_bad;
  logic [1:0]            w_off;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_ext;

  assign w_off      = ALUResultM_i[1:0];
  assign w_is_store = MemWriteM_i;
  assign w_start    = (r_state == IDLE) && ValidM_i && (MemReadM_i || MemWriteM_i);
  // The start cycle itself must already freeze upstream
  assign StallM_o   = (r_state != IDLE) || w_start;

  // Legality check, byte enables and lane-replicated store data
  always_comb begin
    w_bad   = 1'b0;
    w_be    = 4'b1111;
    w_wdata = WriteDataM_i;
    if (w_is_store) begin
      case (Funct3M_i)
        F3_SB: begin
          w_be    = 4'b0001 << w_off;
          w_wdata = {4{WriteDataM_i[7:0]}};
        end
        F3_SH: begin
          w_bad   = w_off[0];
          w_be    = 4'b0011 << w_off;
          w_wdata = {2{WriteDataM_i[15:0]}};
        end
        F3_SW:   w_bad = (w_off != 2'b00);
        default: w_bad = 1'b1;
      endcase
    end else begin
      case (Funct3M_i)
        F3_LB, F3_LBU: w_be = 4'b0001 << w_off;
        F3_LH, F3_LHU: begin
          w_bad = w_off[0];
          w_be  = 4'b0011 << w_off;
        end
        F3_LW:   w_bad = (w_off != 2'b00);
        default: w_bad = 1'b1;
      endcase
    end
  end

  load_extend u_load_extend (
    .rdata    (rdata_i),
    .offset   (r_off),
    .funct3   (r_funct3),
    .data_ext (w_ext)
  );

  // Access FSM with registered bus and completion outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_rd        <= 5'd0;
      r_funct3    <= 3'd0;
      r_off       <= 2'd0;
      req_o       <= 1'b0;
      we_o        <= 1'b0;
      addr_o      <= '0;
      wdata_o     <= '0;
      be_o        <= 4'b0000;
      ReadDataM_o <= '0;
      RdW_o       <= 5'd0;
      DoneM_o     <= 1'b0;
      FaultM_o    <= 1'b0;
    end else begin
      DoneM_o  <= 1'b0;
      FaultM_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            if (w_bad) begin
              // Rejected before reaching the bus; completes as a fault
              DoneM_o  <= 1'b1;
              FaultM_o <= 1'b1;
              RdW_o    <= RdM_i;
            end else begin
              req_o    <= 1'b1;
              we_o     <= w_is_store;
              addr_o   <= {ALUResultM_i[ADDR_WIDTH-1:2], 2'b00};
              be_o     <= w_be;
              wdata_o  <= w_wdata;
              r_rd     <= RdM_i;
              r_funct3 <= Funct3M_i;
              r_off    <= w_off;
              r_state  <= REQ;
            end
          end
        end
        REQ: begin
          if (gnt_i) begin
            req_o <= 1'b0;
            if (we_o) begin
              DoneM_o <= 1'b1;
              RdW_o   <= r_rd;
              r_state <= IDLE;
            end else begin
              r_state <= RESP;
            end
          end
        end
        RESP: begin
          if (rvalid_i) begin
            ReadDataM_o <= w_ext;
            DoneM_o     <= 1'b1;
            RdW_o       <= r_rd;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule : mem_access_unit
`default_nettype wire
